// File: rtl/park_fee_engine.sv
// Multi-slot parking fee engine: per-slot entry stamps, occupancy tracking and a
// 3-stage exit fee pipeline (wrap-safe elapsed, grace, rate, cap). Optional FEE_ACCUM_EN adds total_revenue.
module park_fee_engine #(
  parameter int TIME_W  = 8,
  parameter int SLOTS   = 4,
  parameter int SLOT_W  = $clog2(SLOTS),
  parameter int FEE_W   = 12,
  parameter int RATE    = 1,
  parameter int GRACE   = 0,
  parameter int MAX_FEE = 2**FEE_W-1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [TIME_W-1:0] current_time,
  input  logic              entry_valid,
  input  logic [SLOT_W-1:0] entry_slot,
  input  logic              exit_valid,
  input  logic [SLOT_W-1:0] exit_slot,
  output logic              exit_ready,
  output logic              fee_valid,
  input  logic              fee_ready,
  output logic [FEE_W-1:0]  fee,
  output logic [SLOT_W-1:0] fee_slot,
  output logic [SLOTS-1:0]  occupancy,
  output logic              err_pulse
`ifdef FEE_ACCUM_EN
  ,
  output logic [31:0]       total_revenue
`endif
);

  localparam int PROD_W = TIME_W + 32;
  localparam logic [TIME_W-1:0] GRACE_T = TIME_W'(GRACE);
  localparam logic [PROD_W-1:0] RATE_P  = PROD_W'(RATE);
  localparam logic [PROD_W-1:0] CAP_P   = PROD_W'(MAX_FEE);

  typedef enum logic [1:0] {IDLE, CALC, MULT, OUT} state_t;

  state_t state, state_next;

  logic [TIME_W-1:0] stamp [SLOTS];
  logic [TIME_W-1:0] t_p0, stamp_p0;
  logic [SLOT_W-1:0] slot_p0;
  logic [TIME_W-1:0] chg_p1;

  logic             exit_take, exit_hit, entry_hit, err_next;
  logic [SLOTS-1:0] occ_mid, occ_next;

  function automatic logic slot_ok(input logic [SLOT_W-1:0] s);
    return 32'(s) < 32'(SLOTS);
  endfunction

  function automatic logic [TIME_W-1:0] charge(input logic [TIME_W-1:0] elapsed);
    return (elapsed > GRACE_T) ? elapsed - GRACE_T : '0;
  endfunction

  function automatic logic [FEE_W-1:0] sat_fee(input logic [TIME_W-1:0] chg);
    logic [PROD_W-1:0] prod;
    prod = PROD_W'(chg) * RATE_P;
    return (prod > CAP_P) ? FEE_W'(CAP_P) : FEE_W'(prod);
  endfunction

`ifdef FEE_ACCUM_EN
  function automatic logic [31:0] sat_add(input logic [31:0] acc, input logic [FEE_W-1:0] f);
    logic [32:0] sum;
    sum = {1'b0, acc} + 33'(f);
    return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  endfunction
`endif

  // Exit is evaluated first so a same-cycle entry on the slot being vacated is legal.
  always_comb begin
    exit_take = exit_valid && (state == IDLE);
    exit_hit  = exit_take && slot_ok(exit_slot) && occupancy[exit_slot];
    occ_mid   = occupancy;
    if (exit_hit) occ_mid[exit_slot] = 1'b0;
    entry_hit = entry_valid && slot_ok(entry_slot) && !occ_mid[entry_slot];
    occ_next  = occ_mid;
    if (entry_hit) occ_next[entry_slot] = 1'b1;
    err_next  = (entry_valid && !entry_hit) || (exit_take && !exit_hit);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    exit_ready = 1'b0;
    fee_valid  = 1'b0;
    case (state)
      IDLE: begin
        exit_ready = 1'b1;
        if (exit_hit) state_next = CALC;
      end
      CALC: state_next = MULT;
      MULT: state_next = OUT;
      OUT: begin
        fee_valid = 1'b1;
        if (fee_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SLOTS; i++) stamp[i] <= '0;
      occupancy <= '0;
      err_pulse <= 1'b0;
      t_p0      <= '0;
      stamp_p0  <= '0;
      slot_p0   <= '0;
      chg_p1    <= '0;
      fee       <= '0;
      fee_slot  <= '0;
    end else begin
      occupancy <= occ_next;
      err_pulse <= err_next;
      if (entry_hit) stamp[entry_slot] <= current_time;
      // p0: latch exit time and the slot's pre-entry stamp
      if (exit_hit) begin
        t_p0     <= current_time;
        stamp_p0 <= stamp[exit_slot];
        slot_p0  <= exit_slot;
      end
      // p1: wrap-safe elapsed minus grace
      if (state == CALC) chg_p1 <= charge(t_p0 - stamp_p0);
      // p2: rate and cap; held stable through OUT
      if (state == MULT) begin
        fee      <= sat_fee(chg_p1);
        fee_slot <= slot_p0;
      end
    end
  end

`ifdef FEE_ACCUM_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                       total_revenue <= '0;
    else if (fee_valid && fee_ready) total_revenue <= sat_add(total_revenue, fee);
  end
`endif

endmodule

// File: tb/tb_park_fee_engine.sv
// Directed bench for park_fee_engine: three instances (default, grace/rate, grace/rate/cap)
// share one stimulus; a vector table plus hand sequences for the multi-cycle corners.
module tb_park_fee_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [7:0] current_time;
  logic       entry_valid, exit_valid, fee_ready;
  logic [1:0] entry_slot, exit_slot;

  logic        exit_ready_a, exit_ready_b, exit_ready_c;
  logic        fee_valid_a, fee_valid_b, fee_valid_c;
  logic [11:0] fee_a, fee_b, fee_c;
  logic [1:0]  fee_slot_a, fee_slot_b, fee_slot_c;
  logic [3:0]  occ_a, occ_b, occ_c;
  logic        err_a, err_b, err_c;
`ifdef FEE_ACCUM_EN
  logic [31:0] rev_a, rev_b, rev_c;
`endif

  park_fee_engine dut_a (
    .clk(clk), .reset(reset), .current_time(current_time),
    .entry_valid(entry_valid), .entry_slot(entry_slot),
    .exit_valid(exit_valid), .exit_slot(exit_slot), .exit_ready(exit_ready_a),
    .fee_valid(fee_valid_a), .fee_ready(fee_ready), .fee(fee_a), .fee_slot(fee_slot_a),
    .occupancy(occ_a), .err_pulse(err_a)
`ifdef FEE_ACCUM_EN
    , .total_revenue(rev_a)
`endif
  );

  park_fee_engine #(.RATE(3), .GRACE(5)) dut_b (
    .clk(clk), .reset(reset), .current_time(current_time),
    .entry_valid(entry_valid), .entry_slot(entry_slot),
    .exit_valid(exit_valid), .exit_slot(exit_slot), .exit_ready(exit_ready_b),
    .fee_valid(fee_valid_b), .fee_ready(fee_ready), .fee(fee_b), .fee_slot(fee_slot_b),
    .occupancy(occ_b), .err_pulse(err_b)
`ifdef FEE_ACCUM_EN
    , .total_revenue(rev_b)
`endif
  );

  park_fee_engine #(.RATE(3), .GRACE(5), .MAX_FEE(40)) dut_c (
    .clk(clk), .reset(reset), .current_time(current_time),
    .entry_valid(entry_valid), .entry_slot(entry_slot),
    .exit_valid(exit_valid), .exit_slot(exit_slot), .exit_ready(exit_ready_c),
    .fee_valid(fee_valid_c), .fee_ready(fee_ready), .fee(fee_c), .fee_slot(fee_slot_c),
    .occupancy(occ_c), .err_pulse(err_c)
`ifdef FEE_ACCUM_EN
    , .total_revenue(rev_c)
`endif
  );

  typedef struct {
    int slot;
    int t_in;
    int t_out;
    int fee_a;
    int fee_b;
    int fee_c;
  } vec_t;

  vec_t vecs[6];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_entry(input int slot, input int t);
    entry_valid  = 1'b1;
    entry_slot   = 2'(slot);
    current_time = 8'(t);
    step();
    entry_valid  = 1'b0;
  endtask

  task automatic do_exit(input int slot, input int t);
    exit_valid   = 1'b1;
    exit_slot    = 2'(slot);
    current_time = 8'(t);
    step();
    exit_valid   = 1'b0;
  endtask

  // Called right after the accepting edge; lat counts edges from acceptance.
  task automatic wait_fee(output int lat);
    lat = 1;
    while (!fee_valid_a && lat < 20) begin
      step();
      lat++;
    end
  endtask

  task automatic release_fee();
    fee_ready = 1'b1;
    step();
    fee_ready = 1'b0;
  endtask

  initial begin
    int lat;
    int seen;

    vecs[0] = '{2, 10,  25,  15,  30, 30};
    vecs[1] = '{0, 250, 4,   10,  15, 15};
    vecs[2] = '{1, 100, 103, 3,   0,  0};
    vecs[3] = '{3, 100, 120, 20,  45, 40};
    vecs[4] = '{1, 7,   7,   0,   0,  0};
    vecs[5] = '{0, 0,   255, 255, 750, 40};

    reset = 1'b1;
    current_time = '0;
    entry_valid = 1'b0; entry_slot = '0;
    exit_valid = 1'b0;  exit_slot = '0;
    fee_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    step();

    chk("reset exit_ready", exit_ready_a, 1);
    chk("reset fee_valid", fee_valid_a, 0);
    chk("reset fee", fee_a, 0);
    chk("reset fee_slot", fee_slot_a, 0);
    chk("reset occupancy", occ_a, 0);
    chk("reset err_pulse", err_a, 0);

    for (int i = 0; i < 6; i++) begin
      do_entry(vecs[i].slot, vecs[i].t_in);
      chk($sformatf("vec%0d occ set", i), occ_a[vecs[i].slot], 1);
      chk($sformatf("vec%0d entry err", i), err_a, 0);
      do_exit(vecs[i].slot, vecs[i].t_out);
      chk($sformatf("vec%0d occ clear", i), occ_a[vecs[i].slot], 0);
      chk($sformatf("vec%0d exit_ready busy", i), exit_ready_a, 0);
      wait_fee(lat);
      chk($sformatf("vec%0d latency", i), lat, 3);
      chk($sformatf("vec%0d fee_a", i), fee_a, vecs[i].fee_a);
      chk($sformatf("vec%0d fee_b", i), fee_b, vecs[i].fee_b);
      chk($sformatf("vec%0d fee_c", i), fee_c, vecs[i].fee_c);
      chk($sformatf("vec%0d fee_valid_bc", i), {fee_valid_b, fee_valid_c}, 2'b11);
      chk($sformatf("vec%0d fee_slot", i), fee_slot_a, vecs[i].slot);
      release_fee();
      chk($sformatf("vec%0d fee_valid drop", i), fee_valid_a, 0);
      chk($sformatf("vec%0d exit_ready back", i), exit_ready_a, 1);
    end

    // Exit on a free slot: single error pulse, no fee
    do_exit(1, 80);
    chk("free exit err", err_a, 1);
    chk("free exit idle", exit_ready_a, 1);
    seen = 0;
    step();
    chk("free exit err one cycle", err_a, 0);
    repeat (4) begin
      if (fee_valid_a) seen = 1;
      step();
    end
    chk("free exit no fee", seen, 0);

    // Entry on an occupied slot keeps the original stamp
    do_entry(3, 50);
    do_entry(3, 60);
    chk("dup entry err", err_a, 1);
    step();
    chk("dup entry err one cycle", err_a, 0);
    do_exit(3, 70);
    wait_fee(lat);
    chk("dup entry original stamp fee", fee_a, 20);
    release_fee();

    // Backpressure: output held stable, no new exits
    do_entry(2, 30);
    do_exit(2, 40);
    wait_fee(lat);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp%0d fee", k), fee_a, 10);
      chk($sformatf("bp%0d fee_slot", k), fee_slot_a, 2);
      chk($sformatf("bp%0d exit_ready", k), exit_ready_a, 0);
      chk($sformatf("bp%0d fee_valid", k), fee_valid_a, 1);
      step();
    end
    release_fee();

    // Same-cycle entry and exit on slot 1
    do_entry(1, 20);
    entry_valid = 1'b1; entry_slot = 2'd1;
    exit_valid  = 1'b1; exit_slot  = 2'd1;
    current_time = 8'd35;
    step();
    entry_valid = 1'b0; exit_valid = 1'b0;
    chk("same-cycle occ", occ_a[1], 1);
    chk("same-cycle err", err_a, 0);
    wait_fee(lat);
    chk("same-cycle old stamp fee", fee_a, 15);
    chk("same-cycle fee_slot", fee_slot_a, 1);
    release_fee();
    do_exit(1, 40);
    wait_fee(lat);
    chk("same-cycle new stamp fee", fee_a, 5);
    release_fee();

    // Reset while in MULT aborts the fee
    do_entry(0, 1);
    do_exit(0, 9);
    step();
    reset = 1'b1;
    #1;
    chk("mid reset fee_valid", fee_valid_a, 0);
    chk("mid reset occupancy", occ_a, 0);
    chk("mid reset exit_ready", exit_ready_a, 1);
    step();
    reset = 1'b0;
    seen = 0;
    repeat (5) begin
      if (fee_valid_a) seen = 1;
      step();
    end
    chk("mid reset no fee after", seen, 0);

`ifdef FEE_ACCUM_EN
    chk("revenue after reset", rev_a, 0);
    do_entry(2, 10);
    do_exit(2, 25);
    wait_fee(lat);
    release_fee();
    do_entry(0, 250);
    do_exit(0, 4);
    wait_fee(lat);
    release_fee();
    chk("revenue 15+10", rev_a, 25);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("revenue cleared", rev_a, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
